// File: rtl/conv1_pool_2x2.sv
// conv1_pool_2x2
//   Streaming 2x2 / stride-2 max-pool followed by ReLU. Consumes one conv1
//   output map in raster order and emits the pooled map in raster order as a
//   valid-qualified stream. One instance per conv1 channel.
//
// Ports
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset (priority over valid_in)
//   valid_in   : in_data carries a pixel this cycle
//   in_data    : signed conv1 pixel, raster order
//   out_data   : pooled + ReLU'd pixel (never negative), held between pulses
//   valid_out  : one-cycle pulse per pooled pixel
//   frame_done : one-cycle pulse with valid_out of the last pooled pixel
module conv1_pool_2x2 #(
  parameter int IN_WIDTH  = 24,
  parameter int IN_HEIGHT = 24,
  parameter int DATA_BIT  = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid_in,
  input  logic signed [DATA_BIT-1:0] in_data,
  output logic        [DATA_BIT-1:0] out_data,
  output logic                       valid_out,
  output logic                       frame_done
);

  localparam int COL_W    = (IN_WIDTH  > 1) ? $clog2(IN_WIDTH)  : 1;
  localparam int ROW_W    = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
  localparam int LB_DEPTH = IN_WIDTH / 2;
  localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  // Signed maximum of two pixels.
  function automatic logic signed [DATA_BIT-1:0] smax(
    input logic signed [DATA_BIT-1:0] a,
    input logic signed [DATA_BIT-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  // ReLU: negative values (sign bit set) clamp to zero.
  function automatic logic [DATA_BIT-1:0] relu(input logic signed [DATA_BIT-1:0] m);
    return m[DATA_BIT-1] ? {DATA_BIT{1'b0}} : m;
  endfunction

  logic        [COL_W-1:0]    r_col;
  logic        [ROW_W-1:0]    r_row;
  logic signed [DATA_BIT-1:0] r_hold;
  logic signed [DATA_BIT-1:0] r_linebuf [LB_DEPTH];
  logic        [DATA_BIT-1:0] r_out_data;
  logic                       r_valid_out;
  logic                       r_frame_done;

  logic        [COL_W-1:0]    w_col_half;
  logic        [LB_AW-1:0]    w_lb_idx;
  logic signed [DATA_BIT-1:0] w_lb_rd;
  logic signed [DATA_BIT-1:0] w_max_hp;
  logic signed [DATA_BIT-1:0] w_max_lp;
  logic                       w_col_last;
  logic                       w_row_last;

  // Each line-buffer entry covers one horizontal pair of input columns.
  assign w_col_half = r_col >> 1;
  assign w_lb_idx   = w_col_half[LB_AW-1:0];
  assign w_lb_rd    = r_linebuf[w_lb_idx];
  assign w_max_hp   = smax(r_hold, in_data);
  assign w_max_lp   = smax(w_lb_rd, in_data);
  assign w_col_last = (r_col == COL_W'(IN_WIDTH - 1));
  assign w_row_last = (r_row == ROW_W'(IN_HEIGHT - 1));

  // Raster counters, hold register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col        <= {COL_W{1'b0}};
      r_row        <= {ROW_W{1'b0}};
      r_hold       <= {DATA_BIT{1'b0}};
      r_out_data   <= {DATA_BIT{1'b0}};
      r_valid_out  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_valid_out  <= 1'b0;
      r_frame_done <= 1'b0;
      if (valid_in) begin
        if (w_col_last) begin
          r_col <= {COL_W{1'b0}};
          r_row <= w_row_last ? {ROW_W{1'b0}} : r_row + ROW_W'(1);
        end else begin
          r_col <= r_col + COL_W'(1);
        end
        // Odd-column, even-row beats only touch the line buffer (separate block).
        case ({r_row[0], r_col[0]})
          2'b00: r_hold <= in_data;
          2'b10: r_hold <= w_max_lp;
          2'b11: begin
            r_out_data   <= relu(w_max_hp);
            r_valid_out  <= 1'b1;
            r_frame_done <= w_col_last && w_row_last;
          end
          default: r_hold <= r_hold;
        endcase
      end
    end
  end

  // Line buffer: top-row pair maximum, consumed on the following row.
  always_ff @(posedge clk) begin
    if (!rst && valid_in && !r_row[0] && r_col[0]) begin
      r_linebuf[w_lb_idx] <= w_max_hp;
    end
  end

  assign out_data   = r_out_data;
  assign valid_out  = r_valid_out;
  assign frame_done = r_frame_done;

endmodule
